cic_comp_fir: RTL and testbench
===============================

# cic_comp_fir

Time-multiplexed compensating FIR that sits directly downstream of `cic_decimator`. It takes the CIC's decimated samples and flattens the CIC passband droop using runtime-loadable coefficients. It can optionally decimate by a further factor of 2, and emits rounded, saturated samples to the channel filter / demod chain. It uses a single multiply-accumulate unit, sequenced by an FSM over a circular sample buffer.

## Interface
- `DATA_WIDTH`, 32: signed sample width, input and output.
- `COEF_WIDTH`, 18: signed coefficient width.
- `COEF_FRAC`, 16: coefficient fractional bits (1.0 = 65536).
- `TAPS`, 16: filter length. Must be a power of 2, ≥ 4.
- `DECIM`, 2: output decimation. Only 1 or 2 is legal.

Ports:
- `clk`  in  1  processing clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  signed sample from the CIC.
- `data_valid`  in  1  one-cycle strobe qualifying `data_in`.
- `coef_wr_en`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  tap index.
- `coef_data`  in  COEF_WIDTH  signed coefficient.
- `overrun_clr`  in  1  clears `overrun`.
- `data_out`  out  DATA_WIDTH  filtered sample, held between strobes.
- `output_valid`  out  1  one-cycle strobe qualifying `data_out`.
- `busy`  out  1  high while a convolution is in progress.
- `overrun`  out  1  sticky flag: an input sample was dropped.

## Operation
- Reset state:
  - Sample buffer, accumulator, write pointer and decimation phase are all 0.
  - FSM is in IDLE.
  - `data_out`, `output_valid`, `busy` and `overrun` are all 0.
  - Coefficients reload to a unit impulse: coef[0] = 1<<COEF_FRAC, all others 0. The block therefore passes samples straight through after reset.
- Sample acceptance: `data_valid` is accepted only when `busy` = 0.
  - An accepted sample is written at the write pointer, and the pointer increments modulo TAPS.
  - The decimation phase then increments modulo DECIM.
  - The sample that makes the phase wrap to 0 (every sample when DECIM = 1) triggers a convolution.
- Overrun: `data_valid` while `busy` = 1 drops the sample. The buffer, pointer and phase are unchanged, and `overrun` is set.
  - `overrun` clears only on `rst` or `overrun_clr`.
  - If `overrun_clr` and a drop occur in the same cycle, set wins.
- FSM states:
  - IDLE → MAC on a trigger.
  - MAC runs for TAPS cycles with k = 0..TAPS-1, computing acc += coef[k] * x[n-k]. Here x[n] is the triggering sample and indices wrap modulo TAPS. The accumulator clears on entry.
  - MAC → DRAIN for 1 cycle, to flush the registered multiplier.
  - DRAIN → OUT for 1 cycle, which rounds, saturates and registers the result.
  - OUT → IDLE.
- Arithmetic:
  - Product width is DATA_WIDTH + COEF_WIDTH.
  - Accumulator width is DATA_WIDTH + COEF_WIDTH + $clog2(TAPS), so the accumulator can never overflow.
  - Rounding is round-half-up: add 1<<(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - The result saturates to the signed DATA_WIDTH range: 0x7FFFFFFF / 0x80000000 at the default width.
- Coefficient writes:
  - With `coef_wr_en` = 1 and `busy` = 0, coef[coef_addr] is written at the clock edge.
  - A write while `busy` = 1 is ignored.
  - If a write and a trigger occur in the same cycle, the new coefficient applies to that convolution.
- Reset mid-operation: `rst` at any time aborts the convolution. No `output_valid` is produced, and the full reset state applies on the next cycle.

## Timing
- Trigger `data_valid` in cycle T → `busy` = 1 from cycle T+1 through T+TAPS+2, and `output_valid` = 1 in cycle T+TAPS+3 with `data_out` updated the same cycle.
- `busy` is low again in cycle T+TAPS+3, so a new `data_valid` is accepted in the same cycle as `output_valid`.
- The default latency is 19 clocks.
- Minimum input spacing for lossless operation is TAPS+3 clocks per triggering sample. Non-trigger samples (DECIM = 2, phase 0) are accepted on any cycle where `busy` = 0.
- `data_out` holds its value until the next OUT. `output_valid` is never high for two consecutive cycles.

## Test plan
- Pass-through after reset, default parameters:
  - Stimulus: inputs 100, 200, 300, 400, spaced 20 clocks apart.
  - Response: exactly two outputs, 200 then 400, each 19 cycles after the 2nd and 4th `data_valid`. `overrun` stays 0.
- Averaging filter:
  - Stimulus: load all 16 coefs = 4096, then feed a constant 1600.
  - Response: the first output is 200. Output ramps by 200 per output, reaching 1600 after 16 input samples, then holds at 1600.
- Saturation:
  - Stimulus: set coef[0] = 0x1FFFF and input 0x7FFFFFFF, then coef[0] = 0x1FFFF with input 0x80000000.
  - Response: `data_out` = 0x7FFFFFFF for the first, and 0x80000000 for the second.
- Rounding:
  - Stimulus: set coef[0] = 32768 and drive inputs 3 and −3 with DECIM = 1.
  - Response: outputs 2 and −1.
- Overrun and ignored write:
  - Stimulus: drive `data_valid` at T+5 after a trigger at T, and `coef_wr_en` during `busy`.
  - Response: the sample is dropped and `overrun` = 1 from T+6. No extra output is produced, and the coefficient is unchanged. `overrun_clr` returns `overrun` to 0 on the next cycle.
- Reset mid-MAC:
  - Stimulus: assert `rst` at T+8, then release it.
  - Response: no `output_valid` is produced. `busy`, `data_out` and `overrun` read 0, and the next input passes through unchanged (impulse coefficients restored).

Source files
------------

// File: rtl/cic_comp_fir_if.sv
// Sample, coefficient and status bundle of the CIC compensating FIR.
// The master side drives samples and coefficients; the filter is the slave.
interface cic_comp_fir_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 18,
    parameter int TAPS       = 16
);
    localparam int AW = $clog2(TAPS);

    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_valid;
    logic                         coef_wr_en;
    logic [AW-1:0]                coef_addr;
    logic signed [COEF_WIDTH-1:0] coef_data;
    logic                         overrun_clr;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         output_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output data_in, data_valid, coef_wr_en, coef_addr, coef_data, overrun_clr,
        input  data_out, output_valid, busy, overrun
    );

    modport slave (
        input  data_in, data_valid, coef_wr_en, coef_addr, coef_data, overrun_clr,
        output data_out, output_valid, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// Time-multiplexed droop-compensation FIR behind the CIC decimator: one MAC,
// circular sample buffer, optional decimate-by-2, rounded and saturated output.
module cic_comp_fir #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 18,
    parameter int COEF_FRAC  = 16,
    parameter int TAPS       = 16,
    parameter int DECIM      = 2
) (
    input  logic          clk,
    input  logic          rst,
    cic_comp_fir_if.slave bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + AW;
    localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PHW-1:0] PH_LAST = PHW'(DECIM - 1);
    localparam logic [PHW-1:0] PH_ONE  = PHW'(1'b1);
    localparam logic [AW-1:0]  K_LAST  = AW'(TAPS - 1);
    localparam logic [AW-1:0]  IDX_ONE = AW'(1'b1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE =
        {{(COEF_WIDTH-1){1'b0}}, 1'b1} << COEF_FRAC;
    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t                       state_r, state_nx_s;
    logic [AW-1:0]                k_r, wr_ptr_r, rd_idx_s;
    logic [PHW-1:0]               phase_r;
    logic                         busy_r, overrun_r, output_valid_r, prod_vld_r;
    logic                         accept_s, trigger_s;
    logic signed [DATA_WIDTH-1:0] buf_r [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_r [TAPS];
    logic signed [DATA_WIDTH-1:0] data_out_r, sat_s;
    logic signed [PW-1:0]         prod_r, prod_s;
    logic signed [ACC_W-1:0]      acc_r, rnd_s, shift_s;

    // Acceptance, tap addressing, product and round/saturate of the accumulator.
    always_comb begin
        accept_s  = bus.data_valid && !busy_r;
        trigger_s = accept_s && (phase_r == PH_LAST);
        // x[n] sits one behind the write pointer, which is frozen while busy.
        rd_idx_s  = wr_ptr_r - IDX_ONE - k_r;
        prod_s    = coef_r[k_r] * buf_r[rd_idx_s];
        rnd_s     = acc_r + RND;
        shift_s   = rnd_s >>> COEF_FRAC;
        if (shift_s > SAT_MAX) begin
            sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shift_s < SAT_MIN) begin
            sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_s = shift_s[DATA_WIDTH-1:0];
        end
    end

    // Next-state decode of the convolution sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (trigger_s) state_nx_s = S_MAC;
                else           state_nx_s = S_IDLE;
            end
            S_MAC: begin
                if (k_r == K_LAST) state_nx_s = S_DRAIN;
                else               state_nx_s = S_MAC;
            end
            S_DRAIN: state_nx_s = S_OUT;
            S_OUT:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Sequencer state, tap counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            k_r     <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != S_IDLE);
            if (state_r == S_MAC) k_r <= k_r + IDX_ONE;
            else                  k_r <= '0;
        end
    end

    // Sample buffer, write pointer, decimation phase, coefficients and overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            phase_r   <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                buf_r[i]  <= '0;
                coef_r[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            if (accept_s) begin
                buf_r[wr_ptr_r] <= bus.data_in;
                wr_ptr_r        <= wr_ptr_r + IDX_ONE;
                phase_r         <= (phase_r == PH_LAST) ? '0 : phase_r + PH_ONE;
            end
            if (bus.coef_wr_en && !busy_r) begin
                coef_r[bus.coef_addr] <= bus.coef_data;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (bus.data_valid && busy_r) overrun_r <= 1'b1;
            else if (bus.overrun_clr)     overrun_r <= 1'b0;
            else                          overrun_r <= overrun_r;
        end
    end

    // Registered multiplier feeding the accumulator one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r     <= '0;
            prod_vld_r <= 1'b0;
            acc_r      <= '0;
        end else begin
            prod_r     <= prod_s;
            prod_vld_r <= (state_r == S_MAC);
            if (state_r == S_IDLE) begin
                acc_r <= '0;
            end else if (prod_vld_r && ((state_r == S_MAC) || (state_r == S_DRAIN))) begin
                acc_r <= acc_r + ACC_W'(prod_r);
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Output register loaded once per convolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r     <= '0;
            output_valid_r <= 1'b0;
        end else begin
            output_valid_r <= (state_r == S_OUT);
            if (state_r == S_OUT) data_out_r <= sat_s;
            else                  data_out_r <= data_out_r;
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.output_valid = output_valid_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: a DECIM=2 instance for most checks and a
// DECIM=1 instance for the rounding vectors.
module tb_cic_comp_fir;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   ov2      = 0;
    int   ov1      = 0;
    int   lat;
    int   base;

    always #5 clk = ~clk;

    cic_comp_fir_if #(.DATA_WIDTH(32), .COEF_WIDTH(18), .TAPS(16)) bus2 ();
    cic_comp_fir_if #(.DATA_WIDTH(32), .COEF_WIDTH(18), .TAPS(16)) bus1 ();

    cic_comp_fir #(.DATA_WIDTH(32), .COEF_WIDTH(18), .COEF_FRAC(16), .TAPS(16), .DECIM(2))
        u_dut (.clk(clk), .rst(rst), .bus(bus2));
    cic_comp_fir #(.DATA_WIDTH(32), .COEF_WIDTH(18), .COEF_FRAC(16), .TAPS(16), .DECIM(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always @(negedge clk) begin
        if (bus2.output_valid) ov2 <= ov2 + 1;
        if (bus1.output_valid) ov1 <= ov1 + 1;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic send2(input logic [31:0] v);
        bus2.data_in    = v;
        bus2.data_valid = 1'b1;
        step();
        bus2.data_valid = 1'b0;
    endtask

    task automatic send1(input logic [31:0] v);
        bus1.data_in    = v;
        bus1.data_valid = 1'b1;
        step();
        bus1.data_valid = 1'b0;
    endtask

    task automatic wcoef2(input int a, input logic [17:0] c);
        bus2.coef_wr_en = 1'b1;
        bus2.coef_addr  = 4'(a);
        bus2.coef_data  = c;
        step();
        bus2.coef_wr_en = 1'b0;
    endtask

    // Counts clock edges from the triggering data_valid edge until output_valid.
    task automatic wait_out2(input int start, output int l);
        l = start;
        while (!bus2.output_valid && l < 60) begin
            step();
            l++;
        end
    endtask

    task automatic wait_out1(input int start, output int l);
        l = start;
        while (!bus1.output_valid && l < 60) begin
            step();
            l++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus2.data_in = '0; bus2.data_valid = 1'b0; bus2.coef_wr_en = 1'b0;
        bus2.coef_addr = '0; bus2.coef_data = '0; bus2.overrun_clr = 1'b0;
        bus1.data_in = '0; bus1.data_valid = 1'b0; bus1.coef_wr_en = 1'b0;
        bus1.coef_addr = '0; bus1.coef_data = '0; bus1.overrun_clr = 1'b0;
        step(3);
        chk ("rst_data_out", bus2.data_out, 32'd0);
        chkb("rst_valid",    bus2.output_valid, 1'b0);
        chkb("rst_busy",     bus2.busy, 1'b0);
        chkb("rst_overrun",  bus2.overrun, 1'b0);
        rst = 1'b0;
        step();

        // Pass-through with impulse coefficients.
        base = ov2;
        send2(32'd100);
        chkb("pt_nontrig_busy", bus2.busy, 1'b0);
        step(19);
        send2(32'd200);
        chkb("pt_trig_busy", bus2.busy, 1'b1);
        wait_out2(1, lat);
        chk ("pt_lat1", lat, 32'd19);
        chk ("pt_out1", bus2.data_out, 32'd200);
        step();
        chkb("pt_valid_pulse", bus2.output_valid, 1'b0);
        chk ("pt_hold", bus2.data_out, 32'd200);
        step(18);
        send2(32'd300);
        step(19);
        send2(32'd400);
        wait_out2(1, lat);
        chk ("pt_lat2", lat, 32'd19);
        chk ("pt_out2", bus2.data_out, 32'd400);
        step(3);
        chk ("pt_count", ov2 - base, 32'd2);
        chkb("pt_overrun", bus2.overrun, 1'b0);

        // Moving average: 16 taps of 1/16 on a constant 1600.
        pulse_rst();
        for (int i = 0; i < 16; i++) wcoef2(i, 18'd4096);
        for (int i = 0; i < 9; i++) begin
            send2(32'd1600);
            send2(32'd1600);
            wait_out2(1, lat);
            chk ("avg_out", bus2.data_out, (i < 8) ? 32'(200 * (i + 1)) : 32'd1600);
        end

        // Saturation at both rails with a gain just under 2.
        pulse_rst();
        wcoef2(0, 18'h1FFFF);
        send2(32'h7FFFFFFF);
        send2(32'h7FFFFFFF);
        wait_out2(1, lat);
        chk ("sat_pos", bus2.data_out, 32'h7FFFFFFF);
        send2(32'h80000000);
        send2(32'h80000000);
        wait_out2(1, lat);
        chk ("sat_neg", bus2.data_out, 32'h80000000);

        // Round-half-up with gain 0.5 on the DECIM=1 instance.
        bus1.coef_wr_en = 1'b1;
        bus1.coef_addr  = 4'd0;
        bus1.coef_data  = 18'd32768;
        step();
        bus1.coef_wr_en = 1'b0;
        base = ov1;
        send1(32'd3);
        wait_out1(1, lat);
        chk ("rnd_lat", lat, 32'd19);
        chk ("rnd_pos", bus1.data_out, 32'd2);
        step();
        send1(32'hFFFFFFFD);
        wait_out1(1, lat);
        chk ("rnd_neg", bus1.data_out, 32'hFFFFFFFF);
        step(2);
        chk ("rnd_count", ov1 - base, 32'd2);

        // Overrun and a coefficient write ignored while busy.
        pulse_rst();
        base = ov2;
        send2(32'd10);
        send2(32'd20);
        step(4);
        bus2.data_in    = 32'd999;
        bus2.data_valid = 1'b1;
        bus2.coef_wr_en = 1'b1;
        bus2.coef_addr  = 4'd0;
        bus2.coef_data  = 18'd0;
        step();
        bus2.data_valid = 1'b0;
        bus2.coef_wr_en = 1'b0;
        chkb("ovr_set", bus2.overrun, 1'b1);
        chkb("ovr_busy", bus2.busy, 1'b1);
        wait_out2(6, lat);
        chk ("ovr_lat", lat, 32'd19);
        chk ("ovr_out", bus2.data_out, 32'd20);
        bus2.overrun_clr = 1'b1;
        step();
        bus2.overrun_clr = 1'b0;
        chkb("ovr_clr", bus2.overrun, 1'b0);
        send2(32'd30);
        chkb("ovr_phase_kept", bus2.busy, 1'b0);
        send2(32'd40);
        wait_out2(1, lat);
        chk ("ovr_coef_kept", bus2.data_out, 32'd40);
        step(3);
        chk ("ovr_count", ov2 - base, 32'd2);

        // Reset in the middle of a convolution.
        wcoef2(0, 18'd32768);
        base = ov2;
        send2(32'd50);
        send2(32'd60);
        step(4);
        bus2.data_valid = 1'b1;
        step();
        bus2.data_valid = 1'b0;
        chkb("mid_ovr_pre", bus2.overrun, 1'b1);
        step(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chkb("mid_busy", bus2.busy, 1'b0);
        chk ("mid_data_out", bus2.data_out, 32'd0);
        chkb("mid_overrun", bus2.overrun, 1'b0);
        step(25);
        chk ("mid_no_output", ov2 - base, 32'd0);
        send2(32'd70);
        send2(32'd80);
        wait_out2(1, lat);
        chk ("mid_lat", lat, 32'd19);
        chk ("mid_impulse", bus2.data_out, 32'd80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
